// File: rtl/mem_merge_if.sv
// Request/response bus shared by memory stages: valid/ready handshake carrying an access.
// The master drives the payload through the out modport; the slave receives it through the in modport.
interface mem_intf #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
);
  logic                  valid;
  logic                  ready;
  logic                  read_enable;
  logic [MASK_WIDTH-1:0] write_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [ID_WIDTH-1:0]   id;

  modport in (
    input  valid, read_enable, write_enable, addr, data, id,
    output ready
  );

  modport out (
    output valid, read_enable, write_enable, addr, data, id,
    input  ready
  );
endinterface

// File: rtl/mem_merge.sv
// Two-to-one round-robin request merger with a registered output stage.
// Each merged request carries its source port in the id MSB, and responses are routed back by that bit.
module mem_merge #(
  parameter logic [31:0] CLOCK_INFO = 'b0
) (
  input logic clk,
  input logic rst,
  mem_intf.in  mem_in0,
  mem_intf.in  mem_in1,
  mem_intf.out mem_out,
  mem_intf.in  mem_resp_in,
  mem_intf.out mem_resp_out0,
  mem_intf.out mem_resp_out1
);

  localparam int ID_WIDTH = $bits(mem_in0.id);
  localparam int AddrW    = $bits(mem_in0.addr);
  localparam int DataW    = $bits(mem_in0.data);
  localparam int MaskW    = $bits(mem_in0.write_enable);

  localparam bit WidthsOk =
      ($bits(mem_in1.addr) == AddrW) && ($bits(mem_out.addr) == AddrW) &&
      ($bits(mem_resp_in.addr) == AddrW) && ($bits(mem_resp_out0.addr) == AddrW) &&
      ($bits(mem_resp_out1.addr) == AddrW) &&
      ($bits(mem_in1.data) == DataW) && ($bits(mem_out.data) == DataW) &&
      ($bits(mem_resp_in.data) == DataW) && ($bits(mem_resp_out0.data) == DataW) &&
      ($bits(mem_resp_out1.data) == DataW) &&
      ($bits(mem_in1.write_enable) == MaskW) && ($bits(mem_out.write_enable) == MaskW) &&
      ($bits(mem_resp_in.write_enable) == MaskW) &&
      ($bits(mem_resp_out0.write_enable) == MaskW) &&
      ($bits(mem_resp_out1.write_enable) == MaskW) &&
      ($bits(mem_in1.id) == ID_WIDTH) && ($bits(mem_out.id) == ID_WIDTH + 1) &&
      ($bits(mem_resp_in.id) == ID_WIDTH + 1) && ($bits(mem_resp_out0.id) == ID_WIDTH) &&
      ($bits(mem_resp_out1.id) == ID_WIDTH);

  if (!WidthsOk) begin : g_bad_width
    $error("mem_merge: interface widths are inconsistent");
  end

  typedef struct packed {
    logic              re;
    logic [MaskW-1:0]  we;
    logic [AddrW-1:0]  addr;
    logic [DataW-1:0]  data;
    logic [ID_WIDTH:0] id;
  } req_t;

  // Request path
  logic out_valid_q, out_valid_d;
  logic prio_q, prio_d;
  req_t out_req_q, out_req_d;
  req_t in_req;
  logic load, grant_vld, grant_sel;

  always_comb begin
    load      = !out_valid_q || mem_out.ready;
    grant_vld = mem_in0.valid || mem_in1.valid;
    // With both ports requesting, prio_q picks; otherwise the lone requester wins.
    grant_sel = (mem_in0.valid && mem_in1.valid) ? prio_q : mem_in1.valid;
  end

  always_comb begin
    if (grant_sel) begin
      in_req = '{re: mem_in1.read_enable, we: mem_in1.write_enable, addr: mem_in1.addr,
                 data: mem_in1.data, id: {1'b1, mem_in1.id}};
    end else begin
      in_req = '{re: mem_in0.read_enable, we: mem_in0.write_enable, addr: mem_in0.addr,
                 data: mem_in0.data, id: {1'b0, mem_in0.id}};
    end
  end

  assign mem_in0.ready = load && grant_vld && !grant_sel && !rst;
  assign mem_in1.ready = load && grant_vld && grant_sel && !rst;

  always_comb begin
    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    prio_d      = prio_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_req_d = in_req;
        prio_d    = !grant_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_req_q   <= out_req_d;
      prio_q      <= prio_d;
    end
  end

  assign mem_out.valid        = out_valid_q;
  assign mem_out.read_enable  = out_req_q.re;
  assign mem_out.write_enable = out_req_q.we;
  assign mem_out.addr         = out_req_q.addr;
  assign mem_out.data         = out_req_q.data;
  assign mem_out.id           = out_req_q.id;

  // Response path: both outputs carry the payload, only the selected one is valid.
  logic resp_sel;
  assign resp_sel = mem_resp_in.id[ID_WIDTH];

  assign mem_resp_out0.valid        = mem_resp_in.valid && !resp_sel;
  assign mem_resp_out0.read_enable  = mem_resp_in.read_enable;
  assign mem_resp_out0.write_enable = mem_resp_in.write_enable;
  assign mem_resp_out0.addr         = mem_resp_in.addr;
  assign mem_resp_out0.data         = mem_resp_in.data;
  assign mem_resp_out0.id           = mem_resp_in.id[ID_WIDTH-1:0];

  assign mem_resp_out1.valid        = mem_resp_in.valid && resp_sel;
  assign mem_resp_out1.read_enable  = mem_resp_in.read_enable;
  assign mem_resp_out1.write_enable = mem_resp_in.write_enable;
  assign mem_resp_out1.addr         = mem_resp_in.addr;
  assign mem_resp_out1.data         = mem_resp_in.data;
  assign mem_resp_out1.id           = mem_resp_in.id[ID_WIDTH-1:0];

  assign mem_resp_in.ready = resp_sel ? mem_resp_out1.ready : mem_resp_out0.ready;

endmodule

// File: tb/tb_mem_merge.sv
// Randomized bench for mem_merge, checked against a queue-based reference model.
// Directed scenarios are run first, followed by a long random soak.
module tb_mem_merge;

  logic clk;
  logic rst;

  mem_intf #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MASK_WIDTH(4)) in0_if ();
  mem_intf #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MASK_WIDTH(4)) in1_if ();
  mem_intf #(.ID_WIDTH(5), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MASK_WIDTH(4)) out_if ();
  mem_intf #(.ID_WIDTH(5), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MASK_WIDTH(4)) rsp_in_if ();
  mem_intf #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MASK_WIDTH(4)) rsp0_if ();
  mem_intf #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MASK_WIDTH(4)) rsp1_if ();

  mem_merge dut (
    .clk          (clk),
    .rst          (rst),
    .mem_in0      (in0_if),
    .mem_in1      (in1_if),
    .mem_out      (out_if),
    .mem_resp_in  (rsp_in_if),
    .mem_resp_out0(rsp0_if),
    .mem_resp_out1(rsp1_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        re;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  id;
  } req_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accepted-but-not-yet-delivered requests and the preferred port.
  logic [57:0] pend[$];
  int          m_prio;
  req_t        cur[2];
  bit          hold[2];
  int          hs_cnt[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [57:0] merged(input req_t r, input int src);
    return {r.re, r.we, r.addr, r.data, src[0], r.id};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.re   = 1'($urandom_range(1));
    r.we   = 4'($urandom);
    r.addr = 16'($urandom);
    r.data = $urandom;
    r.id   = 4'($urandom);
    return r;
  endfunction

  task automatic drive_inputs();
    in0_if.valid        = hold[0];
    in0_if.read_enable  = cur[0].re;
    in0_if.write_enable = cur[0].we;
    in0_if.addr         = cur[0].addr;
    in0_if.data         = cur[0].data;
    in0_if.id           = cur[0].id;
    in1_if.valid        = hold[1];
    in1_if.read_enable  = cur[1].re;
    in1_if.write_enable = cur[1].we;
    in1_if.addr         = cur[1].addr;
    in1_if.data         = cur[1].data;
    in1_if.id           = cur[1].id;
  endtask

  // One clock cycle: drive at negedge, check #1 later, then advance the model.
  task automatic cycle(input int pv, input int pr, input bit rsp_directed);
    bit occ, load, gv, ordy, sel;
    int gs;
    logic [4:0] rid;
    logic [31:0] rdata;
    bit rvalid;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!hold[k] && $urandom_range(99) < pv) begin
        hold[k] = 1'b1;
        cur[k]  = rand_req();
      end
    end
    drive_inputs();
    ordy = ($urandom_range(99) < pr);
    out_if.ready = ordy;
    if (rsp_directed) begin
      rvalid = 1'b1;
      rid    = 5'h15;
      rdata  = 32'h1234;
      rsp0_if.ready = 1'b1;
      rsp1_if.ready = 1'b0;
    end else begin
      rvalid = 1'($urandom_range(1));
      rid    = 5'($urandom);
      rdata  = $urandom;
      rsp0_if.ready = 1'($urandom_range(1));
      rsp1_if.ready = 1'($urandom_range(1));
    end
    rsp_in_if.valid        = rvalid;
    rsp_in_if.id           = rid;
    rsp_in_if.data         = rdata;
    rsp_in_if.addr         = 16'($urandom);
    rsp_in_if.read_enable  = 1'($urandom_range(1));
    rsp_in_if.write_enable = 4'($urandom);
    #1;
    occ  = (pend.size() != 0);
    load = !occ || ordy;
    gv   = hold[0] || hold[1];
    gs   = (hold[0] && hold[1]) ? m_prio : (hold[1] ? 1 : 0);
    check("in0_ready", 64'(in0_if.ready), 64'(load && gv && gs == 0));
    check("in1_ready", 64'(in1_if.ready), 64'(load && gv && gs == 1));
    check("out_valid", 64'(out_if.valid), 64'(occ));
    if (occ) begin
      check("out_payload", 64'({out_if.read_enable, out_if.write_enable, out_if.addr,
                                out_if.data, out_if.id}), 64'(pend[0]));
    end
    sel = rid[4];
    check("rsp0_valid", 64'(rsp0_if.valid), 64'(rvalid && !sel));
    check("rsp1_valid", 64'(rsp1_if.valid), 64'(rvalid && sel));
    check("rsp_id", 64'({rsp0_if.id, rsp1_if.id}), 64'({rid[3:0], rid[3:0]}));
    check("rsp_data", 64'({rsp0_if.data, rsp1_if.data}), {rdata, rdata});
    check("rsp_fields", 64'({rsp1_if.addr, rsp1_if.read_enable, rsp1_if.write_enable}),
          64'({rsp_in_if.addr, rsp_in_if.read_enable, rsp_in_if.write_enable}));
    check("rsp_ready", 64'(rsp_in_if.ready), 64'(sel ? rsp1_if.ready : rsp0_if.ready));
    if (in0_if.valid && in0_if.ready) hs_cnt[0]++;
    if (in1_if.valid && in1_if.ready) hs_cnt[1]++;
    if (occ && ordy) void'(pend.pop_front());
    if (load && gv) begin
      pend.push_back(merged(cur[gs], gs));
      m_prio   = 1 - gs;
      hold[gs] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    in0_if.valid = 1'b1;
    in1_if.valid = 1'b1;
    out_if.ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_out_payload", 64'({out_if.read_enable, out_if.write_enable, out_if.addr,
                                  out_if.data, out_if.id}), 64'd0);
    check("rst_in0_ready", 64'(in0_if.ready), 64'd0);
    check("rst_in1_ready", 64'(in1_if.ready), 64'd0);
    pend.delete();
    m_prio    = 0;
    hs_cnt[0] = 0;
    hs_cnt[1] = 0;
    @(negedge clk);
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    cur[0] = '0;
    cur[1] = '0;
    m_prio = 0;
    drive_inputs();
    out_if.ready = 1'b0;
    rsp_in_if.valid = 1'b0;
    rsp_in_if.id = '0;
    rsp_in_if.data = '0;
    rsp_in_if.addr = '0;
    rsp_in_if.read_enable = 1'b0;
    rsp_in_if.write_enable = '0;
    rsp0_if.ready = 1'b0;
    rsp1_if.ready = 1'b0;

    do_reset();

    // Single write on port 0, visible one cycle after acceptance
    cur[0]  = '{re: 1'b0, we: 4'hf, addr: 16'h0010, data: 32'hDEADBEEF, id: 4'd3};
    hold[0] = 1'b1;
    cycle(0, 100, 1'b0);
    cycle(0, 100, 1'b0);
    check("single_valid", 64'(out_if.valid), 64'd1);
    check("single_id", 64'(out_if.id), 64'h03);
    check("single_addr", 64'(out_if.addr), 64'h10);
    check("single_data", 64'(out_if.data), 64'hDEADBEEF);
    cycle(0, 100, 1'b0);

    // Contention straight out of reset: strict alternation 0,1,0,1,...
    do_reset();
    for (int i = 0; i < 6; i++) cycle(100, 100, 1'b0);
    check("contend_hs0", 64'(hs_cnt[0]), 64'd3);
    check("contend_hs1", 64'(hs_cnt[1]), 64'd3);

    // Back-pressure with a full register, then release
    for (int i = 0; i < 4; i++) cycle(100, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(100, 100, 1'b0);

    // Directed response to port 1 with port 1 stalled
    cycle(0, 100, 1'b1);
    check("rsp_dir_v1", 64'(rsp1_if.valid), 64'd1);
    check("rsp_dir_v0", 64'(rsp0_if.valid), 64'd0);
    check("rsp_dir_id", 64'(rsp1_if.id), 64'd5);
    check("rsp_dir_data", 64'(rsp1_if.data), 64'h1234);
    check("rsp_dir_ready", 64'(rsp_in_if.ready), 64'd0);

    // Reset while the register is full and port 1 is preferred
    do_reset();
    cycle(100, 100, 1'b0);
    cycle(100, 0, 1'b0);
    do_reset();
    cycle(100, 100, 1'b0);
    check("post_rst_in0", 64'(in0_if.ready), 64'd1);
    check("post_rst_in1", 64'(in1_if.ready), 64'd0);

    // Random soak with varying load
    for (int i = 0; i < 10000; i++) begin
      cycle(int'($urandom_range(100)), int'($urandom_range(100)), 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_merge.md
# mem_merge

Two-to-one request merger for `mem_intf` traffic. Requests from two `mem_intf` masters are arbitrated round-robin into a single registered request stream that feeds a `mem_stage` or memory. The request ID is widened by one bit to record the source port. Responses coming back from the memory are routed to the originating port by that bit, which is stripped on the way out.

## Interface

**Parameters**
- `CLOCK_INFO`, default `'b0`: `std_clock_info_t` clock descriptor, carried for consistency with other stages. It has no functional effect.

**Ports**
- `clk` input 1: single clock; every register uses its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_in0` `mem_intf.in` (request from master 0):
  - `ID_WIDTH` = `$bits(mem_in0.id)`
  - `ADDR_WIDTH`, `DATA_WIDTH` and `MASK_WIDTH` are taken from the interface.
- `mem_in1` `mem_intf.in`: request from master 1. All widths are identical to `mem_in0`.
- `mem_out` `mem_intf.out`: merged request stream. `id` width is `ID_WIDTH+1`; the MSB is the source port.
- `mem_resp_in` `mem_intf.in`: responses from memory. `id` width is `ID_WIDTH+1`.
- `mem_resp_out0` `mem_intf.out`: responses routed to master 0. `id` width is `ID_WIDTH`.
- `mem_resp_out1` `mem_intf.out`: responses routed to master 1. `id` width is `ID_WIDTH`.

Width rules are enforced by `STATIC_ASSERT`:
- `addr`, `data` and `write_enable` widths are equal on all six interfaces.
- Response and `mem_out` `id` widths equal the `mem_in0` `id` width plus 1.

## Operation

**Request path: one-entry output register `out_reg` plus a valid flag**
- Load enable: `load = !out_valid || mem_out.ready`.
- Grant, computed combinationally each cycle:
  - If only one input is valid, it wins.
  - If both are valid, the port indicated by the priority pointer `prio` wins.
  - If neither is valid, there is no grant.
- `mem_inK.ready = load && (grant == K) && !rst`. The losing port sees `ready = 0`.
- On handshake of port K, `out_reg` captures that port's fields:
  - `read_enable`, `write_enable`, `addr` and `data` unchanged.
  - `id = {K, mem_inK.id}`.
- Also on handshake of port K: `out_valid` is set to 1 and `prio` becomes `1-K`.
- `mem_out` fields are driven directly from `out_reg`. They hold stable while `valid && !ready`.
- If `load` is true and there is no grant, `out_valid` is cleared to 0.
- `prio` changes only on a successful input handshake.

**Response path: purely combinational**
- `sel = mem_resp_in.id[ID_WIDTH]`.
- The selected `mem_resp_outK` receives:
  - `valid = mem_resp_in.valid`
  - `id = mem_resp_in.id[ID_WIDTH-1:0]`
  - all other fields passed through.
- The non-selected output has `valid = 0`. Its other fields are don't-care, but are driven with the same values.
- `mem_resp_in.ready` equals the selected output's `ready`.
- Both read and write responses are routed. The block does not inspect `read_enable` or `write_enable`.
- There is no ordering constraint between the request path and the response path. Outstanding-request count is unbounded.

## Timing

**Reset values**
- Values while `rst` is asserted, taking effect asynchronously:
  - `out_valid = 0`
  - `out_reg` payload = 0
  - `prio = 0` (port 0 preferred)
  - `mem_in0.ready = mem_in1.ready = 0`
- Response outputs follow `mem_resp_in` even during reset. The upstream memory is itself in reset.

**Latency and throughput**
- Request latency is 1 cycle: an input accepted at edge N appears on `mem_out` after edge N.
- Throughput is 1 request per cycle when `mem_out.ready` stays high.
- With both inputs continuously valid, grants strictly alternate 0,1,0,1,… starting from `prio`.
- Response latency is 0 cycles.

**Boundary conditions**
- Output register full and downstream stalled: both input readys are 0, and `prio` does not change.
- Full register drained with a new request in the same cycle: the register reloads with no bubble.
- Reset mid-transfer: any pending `out_reg` entry is discarded, and `prio` returns to 0.
- Input valid deasserting without a handshake is an upstream protocol violation. The block is not required to behave in any defined way.

## Test plan

- **Single-port request:** `mem_in0` sends one write with `addr=0x10`, `data=0xDEADBEEF`, `id=3`, and `mem_out.ready=1` → `mem_out.valid` is high one cycle later, with `id={0,3}` and all fields equal to the input.
- **Contention:** both inputs are valid every cycle and `mem_out.ready=1` for 6 cycles after reset → `mem_out` source bits read 0,1,0,1,0,1, and each input sees 3 handshakes.
- **Back-pressure:** `mem_out.ready=0` for 4 cycles with `out_valid=1` → `mem_out` fields are stable, both input readys are 0, and `prio` is unchanged. When `ready` returns to 1, the next grant goes to the previously preferred port.
- **Response routing:** `mem_resp_in` carries `id={1,5}` and `data=0x1234` → `mem_resp_out1.valid=1` with `id=5` and `data=0x1234`, and `mem_resp_out0.valid=0`. Holding `mem_resp_out1.ready=0` gives `mem_resp_in.ready=0`.
- **Reset mid-operation:** assert `rst` while `out_valid=1` and `prio=1` → `mem_out.valid` is 0 immediately. After release, with both inputs valid, port 0 wins first.
- **Random soak:** random valid and ready on all interfaces over 10k cycles, checked with a scoreboard → every request appears exactly once, in per-port order. Every response reaches the port given by its ID MSB.
